// File: rtl/dsp_pkg.sv
// Shared definitions for the cascadable multiply-accumulate slice:
// Z-operand select codes and default operand/accumulator widths.
package dsp_pkg;
    localparam int DSP_WIDTH   = 17;
    localparam int DSP_P_WIDTH = 48;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        C      = 3'd1,
        ACC    = 3'd2,
        PCIN   = 3'd3,
        SHPCIN = 3'd4
    } mode_t;
endpackage

// File: rtl/dsp_delay_line.sv
// Fixed-depth register pipeline with asynchronous clear; DEPTH=0 degenerates
// to a plain wire so callers can parameterise stage counts down to zero.
module dsp_delay_line
    import dsp_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [W-1:0] stage_q [DEPTH];
            logic [W-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/dsp_casc_param.sv
// Cascadable unsigned multiply-add slice: P <= A*B + Z with Z chosen from
// zero, the C register, P itself, PCIN or PCIN shifted down by SHIFT.
module dsp_casc_param
    import dsp_pkg::*;
#(
    parameter int WIDTH   = DSP_WIDTH,
    parameter int P_WIDTH = DSP_P_WIDTH,
    parameter int ABREG   = 1,
    parameter int MREG    = 1,
    parameter int SHIFT   = WIDTH
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic [2:0]           mode_i,
    input  logic [WIDTH-1:0]     A_i,
    input  logic [WIDTH-1:0]     B_i,
    input  logic [2*WIDTH-1:0]   C_i,
    input  logic                 C_en_i,
    input  logic [P_WIDTH-1:0]   PCIN_i,
    output logic [2*WIDTH-1:0]   P_o,
    output logic [P_WIDTH-1:0]   PCOUT_o,
    output logic                 valid_o
);
    localparam int LAT = ABREG + MREG + 1;
    localparam int PW  = 2 * WIDTH;

    // Codes outside the named set fall through to a zero addend.
    function automatic logic [P_WIDTH-1:0] z_sel(
        input logic [2:0]         m,
        input logic [P_WIDTH-1:0] p,
        input logic [P_WIDTH-1:0] c,
        input logic [P_WIDTH-1:0] pcin
    );
        case (m)
            C:       z_sel = c;
            ACC:     z_sel = p;
            PCIN:    z_sel = pcin;
            SHPCIN:  z_sel = pcin >> SHIFT;
            default: z_sel = '0;
        endcase
    endfunction

    // Stage p0 -> p1: operand registers
    logic [PW-1:0]    ab_p0, ab_p1;
    logic [WIDTH-1:0] a_p1, b_p1;
    assign ab_p0 = {A_i, B_i};

    dsp_delay_line #(.DEPTH(ABREG), .W(PW)) u_ab (
        .clk_i (clock_i),
        .rst_i (reset_i),
        .d_i   (ab_p0),
        .q_o   (ab_p1)
    );
    assign {a_p1, b_p1} = ab_p1;

    // Stage p1 -> p2: product register
    logic [PW-1:0] m_p1, m_p2;
    assign m_p1 = PW'(a_p1) * PW'(b_p1);

    dsp_delay_line #(.DEPTH(MREG), .W(PW)) u_m (
        .clk_i (clock_i),
        .rst_i (reset_i),
        .d_i   (m_p1),
        .q_o   (m_p2)
    );

    // Control rides a parallel line so mode/valid meet M at the adder.
    logic [3:0] ctl_p0, ctl_p2;
    logic       vld_p2;
    logic [2:0] mode_p2;
    assign ctl_p0 = {valid_i, mode_i};

    dsp_delay_line #(.DEPTH(LAT - 1), .W(4)) u_ctl (
        .clk_i (clock_i),
        .rst_i (reset_i),
        .d_i   (ctl_p0),
        .q_o   (ctl_p2)
    );
    assign {vld_p2, mode_p2} = ctl_p2;

    // Stage p2 -> P: free-running accumulator, wraps modulo 2^P_WIDTH
    logic [PW-1:0]      c_q, c_d;
    logic [P_WIDTH-1:0] p_q, p_d;
    logic               valid_q, valid_d;

    always_comb begin
        c_d     = C_en_i ? C_i : c_q;
        p_d     = P_WIDTH'(m_p2) + z_sel(mode_p2, p_q, P_WIDTH'(c_q), PCIN_i);
        valid_d = vld_p2;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            c_q     <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            p_q     <= p_d;
            valid_q <= valid_d;
        end
    end

    assign P_o     = p_q[PW-1:0];
    assign PCOUT_o = p_q;
    assign valid_o = valid_q;
endmodule

// File: doc/dsp_casc_param.md
DSP_CASC_PARAM -- requirements
Module: dsp_casc_param

Interface
REQ-001 SHALL expose parameter WIDTH, default 17, unsigned operand width of A_i and B_i.
REQ-002 SHALL expose parameter P_WIDTH, default 48, width of the accumulator, PCIN_i and PCOUT_o.
REQ-003 SHALL expose parameter ABREG, default 1, A/B input register stages (0..2).
REQ-004 SHALL expose parameter MREG, default 1, multiplier output register stages (0..1).
REQ-005 SHALL expose parameter SHIFT, default WIDTH, right-shift amount applied to PCIN_i in SHPCIN mode.
REQ-006 SHALL have local constant LAT = ABREG+MREG+1, the operand-to-P_o latency.
REQ-007 clock_i  input  1  single clock; all registers are rising-edge.
REQ-008 reset_i  input  1  reset, asynchronous, active-high.
REQ-009 valid_i  input  1  qualifies A_i, B_i, mode_i in this cycle.
REQ-010 mode_i  input  3  Z-operand select (mode_t), travels with A_i/B_i.
REQ-011 A_i, B_i  input  WIDTH each  unsigned multiplicand and multiplier.
REQ-012 C_i  input  2*WIDTH  addend, loaded into the C register when C_en_i=1.
REQ-013 C_en_i  input  1  C register load enable.
REQ-014 PCIN_i  input  P_WIDTH  cascade input from the previous slice, used unregistered.
REQ-015 P_o  output  2*WIDTH  low 2*WIDTH bits of the P register.
REQ-016 PCOUT_o  output  P_WIDTH  full P register, to the next slice.
REQ-017 valid_o  output  1  P_o/PCOUT_o hold the result of an operation issued LAT cycles earlier.

Function
REQ-018 Product M SHALL be A*B, zero-extended to P_WIDTH, taken after ABREG and MREG stages.
REQ-019 mode_i and valid_i SHALL be delayed by ABREG+MREG stages so they reach the P stage aligned with M.
REQ-020 At the P stage P SHALL load M+Z, where Z is selected by the aligned mode: ZERO(0)=0, C(1)=C register, ACC(2)=current P, PCIN(3)=PCIN_i, SHPCIN(4)=PCIN_i>>SHIFT (logical); codes 5..7 SHALL select Z=0.
REQ-021 The sum SHALL wrap modulo 2^P_WIDTH; no saturation, no carry out.
REQ-022 P SHALL load every cycle whether valid is set or not (free-running, matching the hardware slice); valid_o is purely a tag.
REQ-023 The C register SHALL load C_i on a rising edge with C_en_i=1 and hold otherwise; a C value loaded on edge k is visible to a P computation on edge k+1 or later.
REQ-024 In ACC mode on consecutive cycles, each edge SHALL add a new M to the P produced by the previous edge (back-to-back accumulation, no bubble).
REQ-025 With ABREG=0 and MREG=0, LAT=1 and A_i*B_i SHALL reach P on the next edge.

Reset
REQ-026 While reset_i=1 all registers (A/B stages, M, C, mode/valid delay line, P) SHALL be zero, so P_o=0, PCOUT_o=0, valid_o=0.
REQ-027 Assertion mid-operation SHALL discard all in-flight operations; after release the first valid_o SHALL be exactly LAT cycles after the first post-reset valid_i.

Structure
REQ-028 A shared package dsp_pkg SHALL hold mode_t (ZERO, C, ACC, PCIN, SHPCIN) and default constants DSP_WIDTH=17, DSP_P_WIDTH=48.
REQ-029 One sub-module, dsp_delay_line (parameters DEPTH>=0, W; async active-high reset; DEPTH=0 is a wire), SHALL implement the A/B, M and mode/valid pipelines.

Verification
REQ-030 Defaults, mode ZERO, A=0x1FFFF, B=0x1FFFF, valid_i=1 one cycle -> valid_o high exactly 3 cycles later, P_o=0x3FFFC0001.
REQ-031 C_i=5 with C_en_i=1, then mode C, A=3, B=4 -> P_o=17; C_en_i held 0 with C_i changed -> next mode-C result still uses 5.
REQ-032 Mode ACC issued 4 consecutive cycles with A=B=2, starting from P=0 -> PCOUT_o steps 4, 8, 12, 16 on consecutive cycles.
REQ-033 PCIN_i=0x0000_0006_0000 (P_WIDTH=48), mode SHPCIN, A=B=1 -> PCOUT_o=0x3+1=4; mode PCIN same inputs -> 0x60001.
REQ-034 PCIN_i=all ones, mode PCIN, A=B=1 -> PCOUT_o=0 (wrap); mode code 6 -> PCOUT_o=1.
REQ-035 reset_i pulsed 1 cycle between two valid_i issues -> no valid_o for the first, P_o=0 during reset, second result correct at LAT; repeat with ABREG=0, MREG=0 (LAT=1) and ABREG=2 (LAT=4).
